// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//
// This is a configurable up/down counter with a small run-control FSM.
//
// Configuration (limit, direction, reload mode) can only be loaded while the
// sequencer is not counting. When a start command arrives, the counter leaves
// IDLE/DONE and runs. Each tick advances it by one step. When it reaches the
// end value, it produces a one-cycle terminal-count pulse, then either
// reloads or stops in DONE.
//
// Ports
//    clk         rising-edge clock for all state
//    rst         synchronous active-high reset
//    cfg_valid   configuration offered this cycle
//    cfg_ready   configuration accepted when high together with cfg_valid
//    cfg_limit   terminal value (up) or start value (down)
//    cfg_dir     0 = count up 0..limit, 1 = count down limit..0
//    cfg_reload  1 = auto-reload at terminal count, 0 = one-shot
//    start       start command (IDLE/DONE only)
//    stop        abort command, returns to IDLE
//    pause       level-sensitive hold request while running
//    tick        count enable, one step per high cycle
//    count       current count value (registered)
//    busy        high in RUN or HOLD
//    done        high in DONE
//    tc          terminal-count pulse, one cycle after the terminal tick
// ---------------------------------------------------------------------------
module counter_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic             cfg_dir,
   input  logic             cfg_reload,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             tick,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tc
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] count_q,  count_d;
   logic [WIDTH-1:0] limit_q,  limit_d;
   logic             dir_q,    dir_d;
   logic             reload_q, reload_d;
   logic             tc_q,     tc_d;

   logic             idle_or_done;
   logic             cfg_take;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] end_val;

   assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign cfg_take     = cfg_valid && idle_or_done;

   // The start value must reflect a configuration accepted in this same
   // cycle, so it is taken from the effective (post-accept) settings.
   assign start_val = (cfg_take ? cfg_dir : dir_q)
                      ? (cfg_take ? cfg_limit : limit_q)
                      : '0;

   // The end value is used only in RUN. In RUN, no configuration can be
   // accepted, so the latched settings are authoritative.
   assign end_val = dir_q ? '0 : limit_q;

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      limit_d  = limit_q;
      dir_d    = dir_q;
      reload_d = reload_q;
      tc_d     = 1'b0;

      if (cfg_take) begin
         limit_d  = cfg_limit;
         dir_d    = cfg_dir;
         reload_d = cfg_reload;
         count_d  = start_val;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // When stop and start arrive together, stop wins and the
            // sequencer stays in IDLE.
            if (stop) begin
               state_d = ST_IDLE;
               count_d = start_val;
            end else if (start) begin
               state_d = ST_RUN;
               count_d = start_val;
            end
         end

         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               count_d = start_val;
            end else if (pause) begin
               // A tick in the same cycle as pause is ignored.
               state_d = ST_HOLD;
            end else if (tick) begin
               if (count_q == end_val) begin
                  tc_d = 1'b1;
                  if (reload_q) begin
                     count_d = start_val;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else if (dir_q) begin
                  count_d = count_q - ONE;
               end else begin
                  count_d = count_q + ONE;
               end
            end
         end

         ST_HOLD: begin
            if (stop) begin
               state_d = ST_IDLE;
               count_d = start_val;
            end else if (!pause) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         limit_q  <= '1;
         dir_q    <= 1'b0;
         reload_q <= 1'b1;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         limit_q  <= limit_d;
         dir_q    <= dir_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all derived from registered state)
   // ------------------------------------------------------------------------
   assign count     = count_q;
   assign tc        = tc_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_HOLD);
   assign done      = (state_q == ST_DONE);
   assign cfg_ready = idle_or_done;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [3:0] cfg_limit;
   logic       cfg_dir;
   logic       cfg_reload;
   logic       start;
   logic       stop;
   logic       pause;
   logic       tick;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       tc;

   counter_sequencer #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_limit  (cfg_limit),
      .cfg_dir    (cfg_dir),
      .cfg_reload (cfg_reload),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .tick       (tick),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .tc         (tc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      string      name;
      logic [3:0] count;
      logic       busy;
      logic       done;
      logic       tc;
      logic       rdy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Monitor: the DUT presents a new output after every rising edge, and the
   // monitor samples it on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (e.due != cyc || count !== e.count || busy !== e.busy ||
             done !== e.done || tc !== e.tc || cfg_ready !== e.rdy) begin
            n_bad++;
            $display("FAIL %s: got count=%0d busy=%b done=%b tc=%b rdy=%b, want count=%0d busy=%b done=%b tc=%b rdy=%b",
                     e.name, count, busy, done, tc, cfg_ready,
                     e.count, e.busy, e.done, e.tc, e.rdy);
         end
      end
   end

   // Push the expected response to the current inputs, then advance one clock.
   task automatic step(input string name, input int c, input logic b,
                       input logic d, input logic t, input logic r);
      exp_t e;
      e.due   = cyc + 1;
      e.name  = name;
      e.count = 4'(c);
      e.busy  = b;
      e.done  = d;
      e.tc    = t;
      e.rdy   = r;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      rst = 0; cfg_valid = 0; cfg_limit = 0; cfg_dir = 0; cfg_reload = 0;
      start = 0; stop = 0; pause = 0; tick = 0;
   endtask

   task automatic cfg(input int lim, input logic dir, input logic rel);
      cfg_valid = 1; cfg_limit = 4'(lim); cfg_dir = dir; cfg_reload = rel;
   endtask

   int t2_cnt[9] = '{2, 1, 0, 3, 2, 1, 0, 3, 2};

   initial begin
      clear_in();
      rst = 1;
      step("reset0", 0, 0, 0, 0, 1);
      tick = 1; start = 1; cfg_valid = 1;
      step("reset_override", 0, 0, 0, 0, 1);
      clear_in();

      // One-shot up count to 5
      cfg(5, 0, 0);
      step("t1_cfg", 0, 0, 0, 0, 1);
      cfg_valid = 0; start = 1; tick = 1;
      step("t1_start", 0, 1, 0, 0, 0);
      start = 0;
      for (int i = 1; i <= 5; i++) step($sformatf("t1_up%0d", i), i, 1, 0, 0, 0);
      step("t1_terminal", 5, 0, 1, 1, 1);
      step("t1_hold_a", 5, 0, 1, 0, 1);
      step("t1_hold_b", 5, 0, 1, 0, 1);
      tick = 0;

      // Down count with reload, configured while in DONE
      cfg(3, 1, 1);
      step("t2_cfg_in_done", 3, 0, 1, 0, 1);
      cfg_valid = 0; start = 1;
      step("t2_start", 3, 1, 0, 0, 0);
      start = 0; tick = 1;
      for (int i = 0; i < 9; i++)
         step($sformatf("t2_dn%0d", i), t2_cnt[i], 1, 0, (i == 3 || i == 7), 0);
      tick = 0; stop = 1;
      step("t2_stop", 3, 0, 0, 0, 1);
      stop = 0;

      // Pause with tick held high
      cfg(9, 0, 0);
      step("t3_cfg", 0, 0, 0, 0, 1);
      cfg_valid = 0; start = 1;
      step("t3_start", 0, 1, 0, 0, 0);
      start = 0; tick = 1;
      for (int i = 1; i <= 4; i++) step($sformatf("t3_up%0d", i), i, 1, 0, 0, 0);
      pause = 1;
      for (int i = 0; i < 3; i++) step($sformatf("t3_pause%0d", i), 4, 1, 0, 0, 0);
      pause = 0;
      step("t3_release", 4, 1, 0, 0, 0);
      step("t3_up5", 5, 1, 0, 0, 0);
      step("t3_up6", 6, 1, 0, 0, 0);

      // Config attempt while running is refused; stop + tick together
      tick = 0; cfg(2, 1, 1);
      step("t4_cfg_in_run", 6, 1, 0, 0, 0);
      cfg_valid = 0; stop = 1; tick = 1;
      step("t4_stop_tick", 0, 0, 0, 0, 1);
      stop = 0; tick = 0; start = 1;
      step("t4_restart", 0, 1, 0, 0, 0);
      start = 0; tick = 1;
      for (int i = 1; i <= 9; i++) step($sformatf("t4_up%0d", i), i, 1, 0, 0, 0);
      step("t4_terminal", 9, 0, 1, 1, 1);
      start = 1; stop = 1; tick = 0;
      step("t4_start_stop_done", 0, 0, 0, 0, 1);
      start = 0; stop = 0;

      // limit = 0 with reload: every tick is terminal
      cfg(0, 0, 1);
      step("t5_cfg", 0, 0, 0, 0, 1);
      cfg_valid = 0; start = 1;
      step("t5_start", 0, 1, 0, 0, 0);
      start = 0;
      for (int i = 0; i < 3; i++) begin
         tick = 1;
         step($sformatf("t5_tick%0d", i), 0, 1, 0, 1, 0);
         tick = 0;
         step($sformatf("t5_gap%0d", i), 0, 1, 0, 0, 0);
      end
      pause = 1;
      step("t5_hold", 0, 1, 0, 0, 0);
      stop = 1;
      step("t5_stop_hold", 0, 0, 0, 0, 1);
      stop = 0; pause = 0;

      // Reset mid-RUN restores limit=15, dir=0, reload=1
      cfg(15, 1, 0);
      step("t6_cfg", 15, 0, 0, 0, 1);
      cfg(15, 0, 0);
      step("t6_cfg_up", 0, 0, 0, 0, 1);
      cfg_valid = 0; start = 1;
      step("t6_start", 0, 1, 0, 0, 0);
      start = 0; tick = 1;
      for (int i = 1; i <= 7; i++) step($sformatf("t6_up%0d", i), i, 1, 0, 0, 0);
      rst = 1;
      step("t6_rst_mid_run", 0, 0, 0, 0, 1);
      rst = 0; tick = 0; start = 1;
      step("t6_start2", 0, 1, 0, 0, 0);
      start = 0; tick = 1;
      for (int i = 1; i <= 15; i++) step($sformatf("t6_post%0d", i), i, 1, 0, 0, 0);
      step("t6_reload_wrap", 0, 1, 0, 1, 0);
      step("t6_after_wrap", 1, 1, 0, 0, 0);
      clear_in();

      // Let the monitor drain the last expectation, with a bounded wait
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
